// File: rtl/quad_pkg.sv
// Shared types and the Gray-code transition decoder for the rotary encoder front end.
package quad_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} emit_state_t;

  typedef logic signed [3:0] step_t;

  localparam logic [1:0] REST_STATE_DEFAULT = 2'b11;

  typedef struct packed {
    logic  illegal;
    step_t delta;
  } step_dec_t;

  // Position along the forward cycle 00 -> 01 -> 11 -> 10
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic step_dec_t decode_step(input logic [3:0] code);
    logic [1:0] diff;
    step_dec_t  result;
    diff = gray_pos(code[1:0]) - gray_pos(code[3:2]);
    result.illegal = 1'b0;
    result.delta   = step_t'(0);
    case (diff)
      2'd1:    result.delta   = step_t'(1);
      2'd3:    result.delta   = step_t'(-1);
      2'd2:    result.illegal = 1'b1;
      default: result.delta   = step_t'(0);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debounce filter for one encoder channel.
module quad_debounce
  import quad_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic REST_VALUE      = 1'b1
) (
  input  logic display_scan_clk,
  input  logic reset_n,
  input  logic raw,
  output logic filtered
);

  logic       sync_1;
  logic       sync_2;
  logic [3:0] count;

  // Filtered only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge display_scan_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1   <= REST_VALUE;
      sync_2   <= REST_VALUE;
      filtered <= REST_VALUE;
      count    <= 4'd0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == filtered) begin
        count <= 4'd0;
      end else if (count == 4'(DEBOUNCE_CYCLES - 1)) begin
        filtered <= sync_2;
        count    <= 4'd0;
      end else begin
        count <= count + 4'd1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Rotary encoder front end: debounced quadrature decode producing one up/down-qualified pulse per detent.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES  = 4,
  parameter int         STEPS_PER_DETENT = 4,
  parameter logic [1:0] REST_STATE       = REST_STATE_DEFAULT
) (
  input  logic display_scan_clk,
  input  logic reset_n,
  input  logic enc_a,
  input  logic enc_b,
  output logic up,
  output logic down,
  output logic pulse,
  output logic err
);

  localparam step_t STEP_MAX = step_t'(STEPS_PER_DETENT);
  localparam step_t STEP_MIN = -STEP_MAX;

  logic        filt_a;
  logic        filt_b;
  logic [1:0]  cur_ab;
  logic [1:0]  prev_ab;
  step_dec_t   dec;
  step_t       delta;
  step_t       acc;
  step_t       acc_sum;
  step_t       acc_next;
  logic        detent_cw;
  logic        detent_ccw;
  emit_state_t state;

  quad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REST_VALUE     (REST_STATE[1])
  ) u_debounce_a (
    .display_scan_clk(display_scan_clk),
    .reset_n         (reset_n),
    .raw             (enc_a),
    .filtered        (filt_a)
  );

  quad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REST_VALUE     (REST_STATE[0])
  ) u_debounce_b (
    .display_scan_clk(display_scan_clk),
    .reset_n         (reset_n),
    .raw             (enc_b),
    .filtered        (filt_b)
  );

  assign cur_ab = {filt_a, filt_b};

  // Detent is judged only on arrival at the rest position; anything short of a full count is dropped
  always_comb begin
    dec        = decode_step({prev_ab, cur_ab});
    delta      = dec.delta;
    acc_sum    = acc + delta;
    acc_next   = acc;
    detent_cw  = 1'b0;
    detent_ccw = 1'b0;
    if (acc_sum > STEP_MAX) acc_sum = STEP_MAX;
    if (acc_sum < STEP_MIN) acc_sum = STEP_MIN;
    if (dec.illegal) begin
      acc_next = step_t'(0);
    end else if (delta != step_t'(0)) begin
      if (cur_ab == REST_STATE) begin
        detent_cw  = (acc_sum == STEP_MAX);
        detent_ccw = (acc_sum == STEP_MIN);
        acc_next   = step_t'(0);
      end else begin
        acc_next = acc_sum;
      end
    end
  end

  always_ff @(posedge display_scan_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab <= REST_STATE;
      acc     <= step_t'(0);
      err     <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      acc     <= acc_next;
      err     <= dec.illegal;
    end
  end

  // Qualifiers settle a full cycle ahead of the pulse edge and stay put until the next detent
  always_ff @(posedge display_scan_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      up    <= 1'b0;
      down  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pulse <= 1'b0;
          if (detent_cw || detent_ccw) begin
            up    <= detent_cw;
            down  <= detent_ccw;
            state <= SETUP;
          end
        end
        SETUP: begin
          pulse <= 1'b1;
          state <= STROBE;
        end
        STROBE: begin
          pulse <= 1'b0;
          state <= IDLE;
        end
        default: begin
          pulse <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed vector bench for quad_decoder: detent sequences from a table plus hand-written reset/glitch cases.
module tb_quad_decoder;

  logic display_scan_clk;
  logic reset_n;
  logic enc_a;
  logic enc_b;
  logic up;
  logic down;
  logic pulse;
  logic err;

  int compared;
  int mismatched;
  int pulse_count;
  int err_count;
  int wide_count;
  int qual_bad;
  logic rise_up;
  logic rise_down;
  logic prev_pulse;
  logic prev_up;
  logic prev_down;

  typedef struct {
    string      name;
    logic [9:0] seq;
    int         exp_pulses;
    logic       exp_up;
    logic       exp_down;
    int         exp_errs;
  } vec_t;

  vec_t vecs[7];

  quad_decoder #(
    .DEBOUNCE_CYCLES (4),
    .STEPS_PER_DETENT(4),
    .REST_STATE      (2'b11)
  ) dut (
    .display_scan_clk(display_scan_clk),
    .reset_n         (reset_n),
    .enc_a           (enc_a),
    .enc_b           (enc_b),
    .up              (up),
    .down            (down),
    .pulse           (pulse),
    .err             (err)
  );

  initial display_scan_clk = 1'b0;
  always #5 display_scan_clk = ~display_scan_clk;

  // Observe outputs just after each edge: count strobes and capture qualifiers seen the cycle before a rise
  always @(posedge display_scan_clk) begin
    #1;
    if (reset_n) begin
      if (pulse && !prev_pulse) begin
        pulse_count++;
        rise_up   = prev_up;
        rise_down = prev_down;
        if (up !== prev_up || down !== prev_down) qual_bad++;
      end
      if (pulse && prev_pulse) wide_count++;
      if (err) err_count++;
    end
    prev_pulse = pulse;
    prev_up    = up;
    prev_down  = down;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearCounts();
    pulse_count = 0;
    err_count   = 0;
    wide_count  = 0;
    qual_bad    = 0;
    rise_up     = 1'bx;
    rise_down   = 1'bx;
  endtask

  task automatic driveState(input logic [1:0] ab, input int cycles);
    {enc_a, enc_b} = ab;
    repeat (cycles) @(negedge display_scan_clk);
  endtask

  task automatic applyStimulus(input logic [9:0] seq);
    for (int i = 0; i < 5; i++) driveState(seq[9-2*i -: 2], 10);
    repeat (20) @(negedge display_scan_clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    prev_pulse = 1'b0;
    prev_up    = 1'b0;
    prev_down  = 1'b0;
    clearCounts();

    vecs[0] = '{"cw",        {2'b11, 2'b10, 2'b00, 2'b01, 2'b11}, 1, 1'b1, 1'b0, 0};
    vecs[1] = '{"ccw1",      {2'b11, 2'b01, 2'b00, 2'b10, 2'b11}, 1, 1'b0, 1'b1, 0};
    vecs[2] = '{"ccw2",      {2'b11, 2'b01, 2'b00, 2'b10, 2'b11}, 1, 1'b0, 1'b1, 0};
    vecs[3] = '{"ccw3",      {2'b11, 2'b01, 2'b00, 2'b10, 2'b11}, 1, 1'b0, 1'b1, 0};
    vecs[4] = '{"half_turn", {2'b11, 2'b10, 2'b00, 2'b10, 2'b11}, 0, 1'b0, 1'b1, 0};
    vecs[5] = '{"cw_after",  {2'b11, 2'b10, 2'b00, 2'b01, 2'b11}, 1, 1'b1, 1'b0, 0};
    vecs[6] = '{"illegal",   {2'b11, 2'b00, 2'b01, 2'b11, 2'b11}, 0, 1'b1, 1'b0, 1};

    // Reset with arbitrary pin levels, then settle at rest
    reset_n = 1'b0;
    enc_a   = 1'($urandom_range(0, 1));
    enc_b   = 1'($urandom_range(0, 1));
    repeat (3) @(negedge display_scan_clk);
    checkOutput("reset_up",    int'(up),    0);
    checkOutput("reset_down",  int'(down),  0);
    checkOutput("reset_pulse", int'(pulse), 0);
    checkOutput("reset_err",   int'(err),   0);
    {enc_a, enc_b} = 2'b11;
    @(negedge display_scan_clk);
    reset_n = 1'b1;
    clearCounts();
    repeat (50) @(negedge display_scan_clk);
    checkOutput("idle_pulses", pulse_count, 0);
    checkOutput("idle_errs",   err_count,   0);

    // Short glitches on A must never reach the filtered state
    clearCounts();
    for (int g = 0; g < 5; g++) begin
      enc_a = 1'b0;
      repeat (3) @(negedge display_scan_clk);
      enc_a = 1'b1;
      repeat (17) @(negedge display_scan_clk);
    end
    repeat (20) @(negedge display_scan_clk);
    checkOutput("glitch_pulses", pulse_count, 0);
    checkOutput("glitch_errs",   err_count,   0);
    checkOutput("glitch_up",     int'(up),    0);
    checkOutput("glitch_down",   int'(down),  0);

    for (int v = 0; v < 7; v++) begin
      clearCounts();
      applyStimulus(vecs[v].seq);
      checkOutput({vecs[v].name, "_pulses"}, pulse_count, vecs[v].exp_pulses);
      checkOutput({vecs[v].name, "_errs"},   err_count,   vecs[v].exp_errs);
      checkOutput({vecs[v].name, "_wide"},   wide_count,  0);
      checkOutput({vecs[v].name, "_up"},     int'(up),    int'(vecs[v].exp_up));
      checkOutput({vecs[v].name, "_down"},   int'(down),  int'(vecs[v].exp_down));
      if (vecs[v].exp_pulses > 0) begin
        checkOutput({vecs[v].name, "_rise_up"},   int'(rise_up),   int'(vecs[v].exp_up));
        checkOutput({vecs[v].name, "_rise_down"}, int'(rise_down), int'(vecs[v].exp_down));
        checkOutput({vecs[v].name, "_qual"},      qual_bad,        0);
      end
    end

    // Qualifier holds long after the last clockwise detent
    repeat (100) @(negedge display_scan_clk);
    checkOutput("hold_up",   int'(up),   1);
    checkOutput("hold_down", int'(down), 0);

    // Reset part-way through a rotation discards the partial count
    clearCounts();
    driveState(2'b10, 10);
    driveState(2'b00, 10);
    reset_n = 1'b0;
    repeat (2) @(negedge display_scan_clk);
    checkOutput("midreset_up", int'(up), 0);
    reset_n = 1'b1;
    clearCounts();
    driveState(2'b00, 10);
    driveState(2'b01, 10);
    driveState(2'b11, 10);
    repeat (20) @(negedge display_scan_clk);
    checkOutput("midreset_pulses", pulse_count, 0);
    checkOutput("midreset_down",   int'(down),  0);

    clearCounts();
    applyStimulus({2'b11, 2'b10, 2'b00, 2'b01, 2'b11});
    checkOutput("post_reset_pulses", pulse_count, 1);
    checkOutput("post_reset_up",     int'(up),    1);
    checkOutput("post_reset_wide",   wide_count,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
